// File: rtl/duty_phase_loader.sv
// Fetches one frame of duty/phase targets from a synchronous-read BRAM and
// commits it atomically onto DUTY/PHASE with a single UPDATE pulse.
module duty_phase_loader #(
   parameter  int TRANS_NUM    = 249,
   parameter  int WIDTH        = 8,
   parameter  int BRAM_LATENCY = 2,
   localparam int AW           = (TRANS_NUM > 1) ? $clog2(TRANS_NUM) : 1
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 TRIG,
   input  logic                 SILENT,
   output logic [AW-1:0]        BRAM_ADDR,
   input  logic [2*WIDTH-1:0]   BRAM_DATA,
   output logic [WIDTH-1:0]     DUTY  [0:TRANS_NUM-1],
   output logic [WIDTH-1:0]     PHASE [0:TRANS_NUM-1],
   output logic                 UPDATE,
   input  logic                 LPF_DONE,
   output logic                 BUSY,
   output logic [7:0]           DROP_CNT
);

   localparam logic [AW-1:0] LAST = AW'(TRANS_NUM - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_COMMIT,
      S_WAIT_ACK
   } state_t;

   state_t                  state;
   state_t                  next_state;

   logic                    pending;
   logic                    silent_r;
   logic                    issue_done;
   logic [BRAM_LATENCY-1:0] vld_pipe;
   logic [AW-1:0]           cap_idx;
   logic                    lpf_q;
   logic                    lpf_prev;

   logic                    start;
   logic                    issuing;
   logic                    capture;
   logic                    last_cap;
   logic                    lpf_rise;

   logic [WIDTH-1:0]        shadow_duty  [0:TRANS_NUM-1];
   logic [WIDTH-1:0]        shadow_phase [0:TRANS_NUM-1];

   always_ff @(posedge CLK) begin
      if (!RST_N) state <= S_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      start      = 1'b0;
      issuing    = (state == S_FETCH) && !issue_done;
      capture    = (state == S_FETCH) && vld_pipe[BRAM_LATENCY-1];
      last_cap   = capture && (cap_idx == LAST);
      // lpf_prev is forced high outside WAIT_ACK, so a level already high on entry never counts
      lpf_rise   = (state == S_WAIT_ACK) && lpf_q && !lpf_prev;
      unique case (state)
         S_IDLE: begin
            if (TRIG || pending) begin
               start      = 1'b1;
               next_state = S_FETCH;
            end
         end
         S_FETCH: begin
            if (last_cap) next_state = S_COMMIT;
         end
         S_COMMIT: begin
            next_state = silent_r ? S_WAIT_ACK : S_IDLE;
         end
         S_WAIT_ACK: begin
            if (lpf_rise) next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         BRAM_ADDR  <= '0;
         issue_done <= 1'b0;
         vld_pipe   <= '0;
         cap_idx    <= '0;
         pending    <= 1'b0;
         silent_r   <= 1'b0;
         DROP_CNT   <= '0;
         UPDATE     <= 1'b0;
         BUSY       <= 1'b0;
         lpf_q      <= 1'b0;
         lpf_prev   <= 1'b1;
         for (int unsigned i = 0; i < TRANS_NUM; i++) begin
            DUTY[i]  <= '0;
            PHASE[i] <= '0;
         end
      end else begin
         UPDATE   <= last_cap;
         BUSY     <= (next_state != S_IDLE);
         lpf_q    <= LPF_DONE;
         lpf_prev <= (state == S_WAIT_ACK) ? lpf_q : 1'b1;

         if (start) begin
            pending    <= 1'b0;
            silent_r   <= SILENT;
            BRAM_ADDR  <= '0;
            issue_done <= 1'b0;
            cap_idx    <= '0;
         end else if (TRIG && (state != S_IDLE)) begin
            if (!pending)                pending  <= 1'b1;
            else if (DROP_CNT != 8'hFF)  DROP_CNT <= DROP_CNT + 8'd1;
         end

         if (issuing) begin
            if (BRAM_ADDR == LAST) issue_done <= 1'b1;
            else                   BRAM_ADDR  <= BRAM_ADDR + AW'(1);
         end

         // valid bit trails each issued address by the BRAM read latency
         vld_pipe[0] <= issuing;
         for (int unsigned i = 1; i < BRAM_LATENCY; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
         end

         if (capture && (cap_idx != LAST)) cap_idx <= cap_idx + AW'(1);

         if (last_cap) begin
            for (int unsigned i = 0; i < TRANS_NUM; i++) begin
               DUTY[i]  <= (i == TRANS_NUM - 1) ? BRAM_DATA[2*WIDTH-1:WIDTH] : shadow_duty[i];
               PHASE[i] <= (i == TRANS_NUM - 1) ? BRAM_DATA[WIDTH-1:0]       : shadow_phase[i];
            end
         end
      end
   end

   // every shadow word is rewritten before the next commit, so no reset is needed
   always_ff @(posedge CLK) begin
      if (capture) begin
         shadow_duty[cap_idx]  <= BRAM_DATA[2*WIDTH-1:WIDTH];
         shadow_phase[cap_idx] <= BRAM_DATA[WIDTH-1:0];
      end
   end

endmodule

// File: tb/tb_duty_phase_loader.sv
// Scoreboard bench for duty_phase_loader: default build plus a TRANS_NUM=1,
// BRAM_LATENCY=1 corner instance.
module tb_duty_phase_loader;

   localparam int N = 249;
   localparam int W = 8;
   localparam int L = 2;

   logic        CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic        RST_N, TRIG, SILENT, LPF_DONE;
   logic [7:0]  BRAM_ADDR;
   logic [15:0] BRAM_DATA;
   logic [7:0]  DUTY  [0:N-1];
   logic [7:0]  PHASE [0:N-1];
   logic        UPDATE, BUSY;
   logic [7:0]  DROP_CNT;

   logic        TRIG1, SILENT1, LPF_DONE1;
   logic [0:0]  BRAM_ADDR1;
   logic [15:0] BRAM_DATA1;
   logic [7:0]  DUTY1  [0:0];
   logic [7:0]  PHASE1 [0:0];
   logic        UPDATE1, BUSY1;
   logic [7:0]  DROP_CNT1;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int seed   = 0;

   typedef struct {
      int cyc;
      int seed;
   } exp_t;
   exp_t sbq[$];

   duty_phase_loader #(.TRANS_NUM(N), .WIDTH(W), .BRAM_LATENCY(L)) dut (
      .CLK(CLK), .RST_N(RST_N), .TRIG(TRIG), .SILENT(SILENT),
      .BRAM_ADDR(BRAM_ADDR), .BRAM_DATA(BRAM_DATA),
      .DUTY(DUTY), .PHASE(PHASE), .UPDATE(UPDATE),
      .LPF_DONE(LPF_DONE), .BUSY(BUSY), .DROP_CNT(DROP_CNT)
   );

   duty_phase_loader #(.TRANS_NUM(1), .WIDTH(W), .BRAM_LATENCY(1)) dut1 (
      .CLK(CLK), .RST_N(RST_N), .TRIG(TRIG1), .SILENT(SILENT1),
      .BRAM_ADDR(BRAM_ADDR1), .BRAM_DATA(BRAM_DATA1),
      .DUTY(DUTY1), .PHASE(PHASE1), .UPDATE(UPDATE1),
      .LPF_DONE(LPF_DONE1), .BUSY(BUSY1), .DROP_CNT(DROP_CNT1)
   );

   function automatic logic [15:0] word(input int i, input int s);
      logic [7:0] d, p;
      d = 8'(i + s);
      p = 8'(255 - i + 3 * s);
      return {d, p};
   endfunction

   // BRAM models: latency 2 for the main instance, 1 for the corner instance
   logic [15:0] rd0, rd1;
   always @(posedge CLK) begin
      rd0        <= word(int'(BRAM_ADDR), seed);
      rd1        <= rd0;
      BRAM_DATA1 <= 16'hA55A ^ {15'b0, BRAM_ADDR1};
   end
   assign BRAM_DATA = rd1;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) step(1);
   endtask

   task automatic expect_frame(input int c, input int s);
      exp_t e;
      e.cyc  = c;
      e.seed = s;
      sbq.push_back(e);
   endtask

   task automatic chk_zero_frame(input string tag);
      int bad;
      bad = 0;
      for (int i = 0; i < N; i++) if (DUTY[i] !== 8'h00 || PHASE[i] !== 8'h00) bad++;
      chk(tag, 32'(bad), 0);
   endtask

   always @(posedge CLK) begin : monitor
      exp_t        e;
      int          bad;
      logic [15:0] w;
      #1;
      if (UPDATE === 1'b1) begin
         if (sbq.size() == 0) begin
            chk("update_unexpected", 1, 0);
         end else begin
            e = sbq.pop_front();
            chk("update_cycle", 32'(cyc), 32'(e.cyc));
            bad = 0;
            for (int i = 0; i < N; i++) begin
               w = word(i, e.seed);
               if (DUTY[i] !== w[15:8] || PHASE[i] !== w[7:0]) bad++;
            end
            chk("frame_data", 32'(bad), 0);
         end
      end
   end

   initial begin
      int          t0, bad;
      logic [15:0] w;
      RST_N = 1'b0; TRIG = 1'b0; SILENT = 1'b0; LPF_DONE = 1'b0;
      TRIG1 = 1'b0; SILENT1 = 1'b0; LPF_DONE1 = 1'b0;

      // reset then idle
      step(3);
      chk_zero_frame("rst_frame");
      chk("rst_update", 32'(UPDATE), 0);
      chk("rst_busy", 32'(BUSY), 0);
      chk("rst_drop", 32'(DROP_CNT), 0);
      chk("rst_addr", 32'(BRAM_ADDR), 0);
      chk("rst1_duty", 32'(DUTY1[0]), 0);
      RST_N = 1'b1;
      step(3);
      chk("idle_busy", 32'(BUSY), 0);
      chk("idle_update", 32'(UPDATE), 0);

      // single non-silent frame
      seed = 0;
      t0 = cyc;
      TRIG = 1'b1;
      expect_frame(t0 + 252, 0);
      step(1);
      TRIG = 1'b0;
      bad = 0;
      for (int k = 0; k <= 250; k++) begin
         if (BRAM_ADDR !== 8'((k < N) ? k : N - 1)) bad++;
         if (BUSY !== 1'b1) bad++;
         if (k == 250) begin
            chk("pre_commit_duty10", 32'(DUTY[10]), 0);
            chk("pre_commit_update", 32'(UPDATE), 0);
         end
         step(1);
      end
      chk("addr_sequence", 32'(bad), 0);
      chk("commit_duty10", 32'(DUTY[10]), 10);
      chk("commit_phase10", 32'(PHASE[10]), 245);
      chk("commit_busy", 32'(BUSY), 1);
      step(1);
      chk("post_busy", 32'(BUSY), 0);
      chk("post_update", 32'(UPDATE), 0);

      // silent handshake; SILENT change mid-frame must be ignored
      seed = 1;
      LPF_DONE = 1'b1;
      SILENT = 1'b1;
      t0 = cyc;
      TRIG = 1'b1;
      expect_frame(t0 + 252, 1);
      step(1);
      TRIG = 1'b0;
      wait_until(t0 + 10);
      SILENT = 1'b0;
      wait_until(t0 + 253);
      LPF_DONE = 1'b0;
      bad = 0;
      while (cyc <= t0 + 554) begin
         if (cyc == t0 + 553) LPF_DONE = 1'b1;
         if (BUSY !== 1'b1) bad++;
         step(1);
      end
      chk("silent_hold", 32'(bad), 0);
      chk("silent_release", 32'(BUSY), 0);

      // overrun: one pending frame, two drops
      seed = 2;
      t0 = cyc;
      TRIG = 1'b1;
      expect_frame(t0 + 252, 2);
      step(1);
      TRIG = 1'b0;
      for (int p = 50; p <= 70; p += 10) begin
         wait_until(t0 + p);
         TRIG = 1'b1;
         if (p == 50) expect_frame(t0 + 505, 2);
         step(1);
         TRIG = 1'b0;
      end
      wait_until(t0 + 100);
      chk("drop_cnt_2", 32'(DROP_CNT), 2);
      wait_until(t0 + 253);
      chk("gap_busy", 32'(BUSY), 0);
      step(1);
      chk("pending_busy", 32'(BUSY), 1);
      chk("pending_addr0", 32'(BRAM_ADDR), 0);
      wait_until(t0 + 506);
      chk("pending_done_busy", 32'(BUSY), 0);
      wait_until(t0 + 760);
      chk("single_followup", 32'(sbq.size()), 0);

      // saturation of DROP_CNT
      t0 = cyc;
      TRIG = 1'b1;
      expect_frame(t0 + 252, 2);
      step(1);
      expect_frame(t0 + 505, 2);
      wait_until(t0 + 252);
      TRIG = 1'b0;
      chk("drop_cnt_252", 32'(DROP_CNT), 252);
      wait_until(t0 + 260);
      TRIG = 1'b1;
      expect_frame(t0 + 758, 2);
      wait_until(t0 + 310);
      TRIG = 1'b0;
      chk("drop_sat", 32'(DROP_CNT), 255);
      wait_until(t0 + 760);
      chk("sat_idle_busy", 32'(BUSY), 0);
      chk("sat_drained", 32'(sbq.size()), 0);

      // reset mid-FETCH
      seed = 3;
      t0 = cyc;
      TRIG = 1'b1;
      step(1);
      TRIG = 1'b0;
      wait_until(t0 + 100);
      RST_N = 1'b0;
      step(1);
      chk_zero_frame("midrst_frame");
      chk("midrst_busy", 32'(BUSY), 0);
      chk("midrst_drop", 32'(DROP_CNT), 0);
      chk("midrst_addr", 32'(BRAM_ADDR), 0);
      RST_N = 1'b1;
      wait_until(t0 + 400);
      chk("abort_no_commit", 32'(DUTY[10]), 0);
      seed = 4;
      t0 = cyc;
      TRIG = 1'b1;
      expect_frame(t0 + 252, 4);
      step(1);
      TRIG = 1'b0;
      wait_until(t0 + 254);
      w = word(10, 4);
      chk("clean_duty10", 32'(DUTY[10]), 32'(w[15:8]));
      chk("clean_busy", 32'(BUSY), 0);

      // TRANS_NUM=1, BRAM_LATENCY=1 corner
      t0 = cyc;
      TRIG1 = 1'b1;
      step(1);
      TRIG1 = 1'b0;
      chk("c1_addr", 32'(BRAM_ADDR1), 0);
      chk("c1_update_early1", 32'(UPDATE1), 0);
      step(1);
      chk("c1_update_early2", 32'(UPDATE1), 0);
      step(1);
      chk("c1_update", 32'(UPDATE1), 1);
      chk("c1_duty", 32'(DUTY1[0]), 32'h A5);
      chk("c1_phase", 32'(PHASE1[0]), 32'h 5A);
      step(1);
      chk("c1_update_end", 32'(UPDATE1), 0);
      chk("c1_busy_end", 32'(BUSY1), 0);
      chk("c1_drop", 32'(DROP_CNT1), 0);

      chk("sb_drained", 32'(sbq.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
